instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  - Fetch stage of the RISC-V core: owns the program counter and drives the word
//    address into the combinational-read instruction memory.
//  - Captures the returned instruction word, tagged with its PC, into a small FIFO
//    that feeds decode through a valid/ready handshake.
//  - Accepts branch/jump redirects from execute; a redirect flushes all queued
//    instructions.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte address loaded into PC on reset
//  DEPTH      2              fetch FIFO entries; power of 2, range 2..8
//  WORD_ADDR  1              1: imem_addr = {2'b00, pc[31:2]} (word-indexed memory); 0: imem_addr = pc
// PORTS
//  clk             in   1   core clock, rising edge
//  rst             in   1   asynchronous reset, active-low (0 = reset asserted)
//  imem_addr       out  32  address to instruction memory, combinational from pc
//  imem_rdata      in   32  instruction word, valid in the same cycle as imem_addr
//  redirect_valid  in   1   execute requests a PC change this cycle
//  redirect_pc     in   32  new byte PC; sampled only when redirect_valid=1
//  stall           in   1   hold PC and block FIFO pushes (e.g. hazard unit)
//  id_valid        out  1   FIFO head holds a valid instruction
//  id_ready        in   1   decode accepts the head this cycle
//  id_instr        out  32  instruction at FIFO head
//  id_pc           out  32  byte PC of id_instr
//  id_pc_plus4     out  32  id_pc + 4, mod 2^32
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - pc = RESET_PC; FIFO count = 0; head and tail pointers = 0.
//    - id_valid = 0; id_instr, id_pc and id_pc_plus4 read 0.
//    - Reset asserted mid-operation discards every in-flight instruction at once.
//  - push = !redirect_valid && !stall && (count < DEPTH || pop).
//  - pop  = id_valid && id_ready && !redirect_valid.
//  - Push cycle:
//    - enqueue {imem_rdata, pc};
//    - pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
//  - No push and no redirect: pc holds.
//  - Latency: an instruction addressed in cycle N appears at the FIFO head, with
//    id_valid=1, in cycle N+1 at the earliest.
//  - Full (count == DEPTH):
//    - pc holds;
//    - a same-cycle pop frees a slot, so push and pop both occur and count is unchanged.
//  - Empty: id_valid = 0. The FIFO is not bypassed; decode never sees imem_rdata
//    combinationally.
//  - Redirect (highest priority):
//    - pc <= redirect_pc and count <= 0;
//    - no push and no pop occur that cycle, even if id_ready=1 or stall=1.
//    - The first instruction from the target reaches the head 2 cycles after the
//      redirect cycle.
//  - Redirect together with stall: the redirect is still taken, and the PC is
//    updated.
//  - Decode rules:
//    - id_* must stay stable while id_valid=1 and id_ready=0;
//    - id_valid never drops without a pop, except on redirect or reset.
//  - count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
//  - PC arithmetic is unsigned 32-bit. pc[1:0] is carried from redirect_pc unchanged.
// CONFIGURATION
//  - Macro FETCH_MISALIGN_CHK_EN.
//  - Defined:
//    - extra output port misalign_err (1 bit);
//    - misalign_err is set on the clock edge where a redirect with
//      redirect_pc[1:0] != 0 is taken, and stays set until reset;
//    - that redirect still loads pc, but with pc[1:0] forced to 2'b00.
//  - Undefined: the port is absent; redirect_pc is loaded verbatim.
// TESTING
//  1. Reset release with RESET_PC=0, imem[k]=k+1, id_ready=1, no stall
//     -> id_pc = 0, 4, 8, ... on consecutive cycles starting 1 cycle after release;
//        id_instr = 1, 2, 3, ...
//  2. id_ready=0 for 6 cycles, DEPTH=2
//     -> count saturates at 2 and pc holds at 8;
//     -> id_pc=0 stays stable;
//     -> on id_ready=1 the sequence 0, 4, 8 continues with no gap or duplicate.
//  3. redirect_valid=1, redirect_pc=32'h40, with FIFO full and id_ready=1
//     -> no pop that cycle; id_valid=0 next cycle;
//     -> id_pc=32'h40 two cycles after the redirect.
//  4. stall=1 for 3 cycles with id_ready=1
//     -> FIFO drains;
//     -> pc unchanged until stall drops, then fetch resumes at the held pc.
//  5. pc=32'hFFFF_FFFC, push -> next pc = 0; id_pc_plus4 = 0 for that entry.
//  6. rst pulsed low mid-stream -> id_valid=0 and pc=RESET_PC immediately (async).
//  7. FETCH_MISALIGN_CHK_EN defined, redirect_pc=32'h42
//     -> misalign_err=1 and pc=32'h40;
//     -> misalign_err cleared only by reset.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, addresses instruction memory and queues {instr, pc} for decode.
// Optional macro FETCH_MISALIGN_CHK_EN adds the sticky misalign_err output.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        misalign_err,
`endif
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

    logic [31:0]      pc_r;
    logic [31:0]      pc_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [31:0]      instr_q_r [DEPTH];
    logic [31:0]      pc_q_r    [DEPTH];
    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic [31:0]      target_s;

    assign valid_s   = (count_r != {CNT_W{1'b0}});
    assign imem_addr = WORD_ADDR ? {2'b00, pc_r[31:2]} : pc_r;

    // Redirect target; the checked build drops the low PC bits of a misaligned target
`ifdef FETCH_MISALIGN_CHK_EN
    assign target_s = {redirect_pc[31:2], 2'b00};
`else
    assign target_s = redirect_pc;
`endif

    // Handshake qualification: a redirect suppresses both push and pop
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!redirect_valid) begin
            pop_s  = valid_s && id_ready;
            push_s = !stall && ((count_r < DEPTH_C) || pop_s);
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Next PC and occupancy
    always_comb begin
        pc_nxt_s    = pc_r;
        count_nxt_s = count_r;
        if (redirect_valid) begin
            pc_nxt_s    = target_s;
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_nxt_s = pc_r + 32'd4;
            end else begin
                pc_nxt_s = pc_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE_C;
                2'b01:   count_nxt_s = count_r - CNT_ONE_C;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // PC, count and pointer registers; a redirect rewinds the queue to empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r    <= RESET_PC;
            count_r <= {CNT_W{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
        end else begin
            pc_r    <= pc_nxt_s;
            count_r <= count_nxt_s;
            if (redirect_valid) begin
                head_r <= {PTR_W{1'b0}};
                tail_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE_C;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE_C;
                end
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q_r[i] <= 32'h0000_0000;
                pc_q_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_q_r[tail_r] <= imem_rdata;
            pc_q_r[tail_r]    <= pc_r;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err_r;

    // Sticky flag: set by any taken redirect with a non-word-aligned target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err_r <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err_r <= 1'b1;
        end
    end

    assign misalign_err = misalign_err_r;
`endif

    // Head outputs read zero whenever the queue is empty
    always_comb begin
        id_valid    = valid_s;
        id_instr    = 32'h0000_0000;
        id_pc       = 32'h0000_0000;
        id_pc_plus4 = 32'h0000_0000;
        if (valid_s) begin
            id_instr    = instr_q_r[head_r];
            id_pc       = pc_q_r[head_r];
            id_pc_plus4 = pc_q_r[head_r] + 32'd4;
        end else begin
            id_instr    = 32'h0000_0000;
            id_pc       = 32'h0000_0000;
            id_pc_plus4 = 32'h0000_0000;
        end
    end

endmodule
